// File: rtl/tpu_pin_bridge.sv
// tpu_pin_bridge: bridge between the narrow pin bus and the tpu core.
// Instructions arrive as little-endian PIN_W-wide beats. Each complete word
// goes into a small circular FIFO that the core drains with valid/ready.
// A wide core result is held until the host reads it back one beat at a time.
module tpu_pin_bridge #(
    parameter int PIN_W    = 8,
    parameter int INSTR_W  = 16,
    parameter int RESULT_W = 16,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PIN_W-1:0]    pin_data,
    input  logic                pin_strobe,
    input  logic                pin_sync,
    input  logic                pin_rd,
    output logic [PIN_W-1:0]    pin_out,
    output logic [4:0]          status,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic [RESULT_W-1:0] result,
    input  logic                result_valid
);

    localparam int IB = INSTR_W / PIN_W;
    localparam int RB = RESULT_W / PIN_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Counters stay one bit wide in the single-beat case and are then held at 0.
    localparam int BW = (IB > 1) ? $clog2(IB) : 1;
    localparam int RW = (RB > 1) ? $clog2(RB) : 1;

    localparam logic [BW-1:0] BEAT_LAST  = BW'(IB - 1);
    localparam logic [RW-1:0] RBEAT_LAST = RW'(RB - 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

    // ---------------------------------------------------------------------
    // Assembler state
    // ---------------------------------------------------------------------
    logic [BW-1:0]      beat_q, beat_d;
    logic [INSTR_W-1:0] asm_q, asm_d;
    logic [INSTR_W-1:0] asm_word_s;
    logic               strobe_s;
    logic               beat_last_s;

    // ---------------------------------------------------------------------
    // FIFO state
    // ---------------------------------------------------------------------
    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               full_s, empty_s;
    logic               push_req_s, push_s, pop_s, drop_s;
    logic               instr_ovf_q, instr_ovf_d;

    // ---------------------------------------------------------------------
    // Result state
    // ---------------------------------------------------------------------
    logic [RESULT_W-1:0] res_q, res_d;
    logic [RW-1:0]       rbeat_q, rbeat_d;
    logic                pending_q, pending_d;
    logic                result_ovf_q, result_ovf_d;
    logic                rd_fire_s, rd_done_s, capture_s, res_drop_s;

    // A sync pulse wins over a coincident beat, which is simply discarded.
    assign strobe_s    = pin_strobe && !pin_sync;
    assign beat_last_s = (beat_q == BEAT_LAST);

    // Merge the incoming beat into its little-endian slot of the assembly word.
    always_comb begin
        asm_word_s = asm_q;
        for (int i = 0; i < IB; i++) begin
            if (beat_q == BW'(i)) begin
                asm_word_s[i*PIN_W +: PIN_W] = pin_data;
            end else begin
                asm_word_s[i*PIN_W +: PIN_W] = asm_q[i*PIN_W +: PIN_W];
            end
        end
    end

    // Next-state for the beat counter and the partial-word register.
    always_comb begin
        beat_d = beat_q;
        asm_d  = asm_q;
        if (pin_sync) begin
            beat_d = {BW{1'b0}};
        end else if (strobe_s) begin
            asm_d = asm_word_s;
            if (beat_last_s) begin
                beat_d = {BW{1'b0}};
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end else begin
            beat_d = beat_q;
        end
    end

    assign full_s     = (cnt_q == CNT_FULL);
    assign empty_s    = (cnt_q == {CW{1'b0}});
    assign pop_s      = !empty_s && instr_ready;
    assign push_req_s = strobe_s && beat_last_s;
    // At full a push is only accepted when a pop frees the slot in the same cycle.
    assign push_s     = push_req_s && (!full_s || pop_s);
    assign drop_s     = push_req_s && full_s && !pop_s;

    // Next-state for FIFO pointers, occupancy and the instruction overflow flag.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q;
        instr_ovf_d = instr_ovf_q;
        if (push_s) begin
            wptr_d = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (pin_sync) begin
            instr_ovf_d = 1'b0;
        end else if (drop_s) begin
            instr_ovf_d = 1'b1;
        end else begin
            instr_ovf_d = instr_ovf_q;
        end
    end

    // Read handshake: the last beat completes a read before any new capture.
    assign rd_fire_s  = pin_rd && pending_q;
    assign rd_done_s  = rd_fire_s && (rbeat_q == RBEAT_LAST);
    assign capture_s  = result_valid && (!pending_q || rd_done_s);
    assign res_drop_s = result_valid && pending_q && !rd_done_s;

    // Next-state for the held result, readout beat and result overflow flag.
    always_comb begin
        res_d        = res_q;
        rbeat_d      = rbeat_q;
        pending_d    = pending_q;
        result_ovf_d = result_ovf_q;
        if (capture_s) begin
            res_d     = result;
            rbeat_d   = {RW{1'b0}};
            pending_d = 1'b1;
        end else if (rd_done_s) begin
            rbeat_d   = {RW{1'b0}};
            pending_d = 1'b0;
        end else if (rd_fire_s) begin
            rbeat_d   = rbeat_q + RW'(1);
        end else begin
            rbeat_d   = rbeat_q;
        end
        if (pin_sync) begin
            result_ovf_d = 1'b0;
        end else if (res_drop_s) begin
            result_ovf_d = 1'b1;
        end else begin
            result_ovf_d = result_ovf_q;
        end
    end

    // Assembler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= {BW{1'b0}};
            asm_q  <= {INSTR_W{1'b0}};
        end else begin
            beat_q <= beat_d;
            asm_q  <= asm_d;
        end
    end

    // FIFO storage: write the completed word at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (push_s) begin
            mem_q[wptr_q] <= asm_word_s;
        end else begin
            mem_q <= mem_q;
        end
    end

    // FIFO control registers and instruction overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= {AW{1'b0}};
            rptr_q      <= {AW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            instr_ovf_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            instr_ovf_q <= instr_ovf_d;
        end
    end

    // Result holding and readout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q        <= {RESULT_W{1'b0}};
            rbeat_q      <= {RW{1'b0}};
            pending_q    <= 1'b0;
            result_ovf_q <= 1'b0;
        end else begin
            res_q        <= res_d;
            rbeat_q      <= rbeat_d;
            pending_q    <= pending_d;
            result_ovf_q <= result_ovf_d;
        end
    end

    // Outputs are pure decodes of registered state.
    assign instr       = mem_q[rptr_q];
    assign instr_valid = !empty_s;
    assign pin_out     = res_q[rbeat_q*PIN_W +: PIN_W];
    assign status      = {instr_ovf_q, result_ovf_q, pending_q, full_s, empty_s};

endmodule

// File: doc/tpu_pin_bridge.md
# tpu_pin_bridge

Parametrised pin-level bridge between the narrow Tiny Tapeout pin bus and the `tpu` core, replacing the fixed 16-bit-in/8-bit-out direct wiring of the current top. It assembles multi-beat instructions from a `PIN_W`-wide input bus into an instruction FIFO and presents them to the core with a valid/ready handshake. It also captures wide core results and returns them to the host one `PIN_W`-wide beat at a time. The block sits between the pin wrapper and `tpu`.

## Interface
- `PIN_W`, 8: pin data width in both directions.
- `INSTR_W`, 16: instruction width. Must be an integer multiple of `PIN_W`. IB = `INSTR_W`/`PIN_W` beats.
- `RESULT_W`, 16: result width. Must be an integer multiple of `PIN_W`. RB = `RESULT_W`/`PIN_W` beats.
- `DEPTH`, 4: instruction FIFO depth. Must be a power of 2 and ≥2.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pin_data`, in, `PIN_W`: instruction beat.
- `pin_strobe`, in, 1: `pin_data` is valid this cycle.
- `pin_sync`, in, 1: resets the beat counter and clears sticky flags.
- `pin_rd`, in, 1: host has consumed the current result beat.
- `pin_out`, out, `PIN_W`: current result beat.
- `status`, out, 5: {`instr_ovf`, `result_ovf`, `pending`, `fifo_full`, `fifo_empty`}.
- `instr`, out, `INSTR_W`: FIFO head word.
- `instr_valid`, out, 1: FIFO is not empty.
- `instr_ready`, in, 1: core accepts `instr`.
- `result`, in, `RESULT_W`: core result.
- `result_valid`, in, 1: `result` is valid this cycle (one-cycle pulse).

## Operation
- **Assembler:**
  - On `pin_strobe`, `pin_data` is written into slot `beat_cnt` of the assembly register. Order is little-endian: beat 0 goes to bits [`PIN_W`-1:0].
  - `beat_cnt` increments per beat and wraps to 0 after beat IB-1.
  - On beat IB-1, the full word (the final beat merged in) is pushed to the FIFO.
- **Push when full:**
  - If the FIFO is full and no pop happens in the same cycle, the word is dropped and sticky `instr_ovf` is set.
  - If a pop happens in the same cycle, the push is accepted and occupancy stays at `DEPTH`.
- **`pin_sync`:**
  - Forces `beat_cnt` to 0 and clears `instr_ovf` and `result_ovf`.
  - Takes priority over a coincident `pin_strobe`; that beat is discarded.
  - Does not flush the FIFO or the result register.
- **FIFO:**
  - Circular buffer with read and write pointers of width log2(`DEPTH`) and an occupancy counter of width log2(`DEPTH`)+1.
  - `instr` is always the head word. Its value is don't-care when the FIFO is empty.
  - A pop occurs when `instr_valid` && `instr_ready`. A pop while empty is impossible by construction.
  - `fifo_full` = (count == `DEPTH`); `fifo_empty` = (count == 0).
- **Result capture:**
  - On `result_valid` with `pending`=0: load the result register, set `rbeat`=0, set `pending`=1.
  - On `result_valid` with `pending`=1: the result is dropped and sticky `result_ovf` is set. The held result is unchanged.
- **Result readout:**
  - `pin_out` = result register beat `rbeat`.
  - `pin_rd` with `pending`=1 advances `rbeat`. On beat RB-1 it instead clears `pending` and returns `rbeat` to 0.
  - `pin_rd` with `pending`=0 is ignored.
  - When `result_valid` and the final `pin_rd` coincide, the read completes first and the new result is captured with no overflow: `pending` stays 1 and `rbeat`=0.
- **Degenerate case:** with IB=1 or RB=1 the beat counters are constant 0.

## Timing
- Reset values (asynchronous): `beat_cnt`, pointers, count, `rbeat`, result register, `pending`, `instr_ovf` and `result_ovf` all 0. Therefore `pin_out`=0, `instr_valid`=0, and `status`=5'b00001.
- Instruction latency:
  - If the final beat is strobed in cycle N, `instr_valid`=1 and `instr` equals the word in cycle N+1 (FIFO was empty before).
  - If `instr_ready`=1 in cycle N+1, the pop happens at that edge.
- Occupancy throughput: one push and one pop per cycle simultaneously.
- Result latency: `result_valid` in cycle K gives `pin_out` = beat 0 and `pending`=1 in cycle K+1.
- Readout latency: `pin_rd` in cycle M shows the next beat, or `pending`=0 after the last beat, in cycle M+1.
- Status bits are registered state or decodes of registered state. There are no combinational paths from pins to `status`.
- Reset asserted mid-frame or mid-readout immediately returns every register to its reset value. Partial words and held results are lost.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame after 1 beat → `status`=5'b00001, `pin_out`=0. Release, strobe 0x34 then 0x12 → `instr`=0x1234 and `instr_valid`=1 one cycle after the second strobe.
- **FIFO fill and drain:**
  - With `instr_ready`=0, push 5 words 0x0001–0x0005 → `fifo_full`=1, `instr_ovf`=1.
  - Drain with `instr_ready`=1 → core sees 0x0001–0x0004 in order, then `fifo_empty`=1.
- **Push and pop at full:** with the FIFO full, pop in the same cycle as the final beat of 0x00AA → count stays 4, `instr_ovf`=0, and 0x00AA emerges last.
- **`pin_sync` resync:**
  - Strobe 1 beat 0xFF, then `pin_sync`, then 0x78 and 0x56 → word 0x5678 is pushed and the stray beat is discarded.
  - `pin_sync` coincident with a strobe → that beat is discarded.
- **Result readout:**
  - `result`=0xBEEF pulsed → `pin_out`=0xEF, then `pin_rd` → 0xBE, then `pin_rd` → `pending`=0.
  - A second `result_valid` while pending → `result_ovf`=1 and the held value is unchanged.
- **Final read coincident with new result:** final `pin_rd` in the same cycle as `result_valid`=0xCAFE → next cycle `pin_out`=0xFE, `pending`=1, `result_ovf`=0.
